stim_train_sequencer: RTL

Parametrised biphasic stimulation pulse-train generator, next generation of the sEEG stim path. Channel count, counter width and magnitude width are generic. Supports finite and infinite modes, graceful charge-balanced stop, bipolar/monopolar electrode selection and a post-run charge-recovery window. Sits between the host config registers and the per-probe stimulator serialisers.

---
 rtl/stim_train_sequencer_pkg.sv | 27 ++
 rtl/stim_train_sequencer_if.sv | 60 ++++++
 rtl/stim_train_sequencer_interval_timer.sv | 31 +++
 rtl/stim_train_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/stim_train_sequencer_pkg.sv
// Shared types for the biphasic stimulation pulse-train sequencer:
// FSM state encoding, default widths and the per-channel effective-mask helper.
package stim_train_sequencer_pkg;

  localparam int unsigned DEF_NUM_CH = 16;
  localparam int unsigned DEF_CNT_W  = 16;
  localparam int unsigned DEF_MAG_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PHASE1   = 3'd1,
    ST_GAP_P    = 3'd2,
    ST_PHASE2   = 3'd3,
    ST_GAP_BP   = 3'd4,
    ST_GAP_TR   = 3'd5,
    ST_RECOVERY = 3'd6
  } stim_state_e;

  // Effective drive of one channel as {pos_eff, neg_eff}: neg only counts in
  // bipolar mode, and a channel claimed by both polarities is dropped from both.
  function automatic logic [1:0] ch_eff(input logic pos, input logic neg, input logic bipolar);
    logic neg_b;
    neg_b = neg & bipolar;
    return {pos & ~neg_b, neg_b & ~pos};
  endfunction

endpackage

// File: rtl/stim_train_sequencer_if.sv
// Host-side bundle of the stim sequencer: latched config, start/stop controls
// and the per-channel drive outputs. The abort input exists only when
// STIM_ABORT_EN is defined.
interface stim_train_sequencer_if
  import stim_train_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned MAG_W  = DEF_MAG_W
);
  logic [CNT_W-1:0]  cfg_pulse_length;
  logic [CNT_W-1:0]  cfg_inter_pulse_delay;
  logic [CNT_W-1:0]  cfg_inter_bipulse_delay;
  logic [CNT_W-1:0]  cfg_inter_train_delay;
  logic [CNT_W-1:0]  cfg_bipulses_per_train;
  logic [CNT_W-1:0]  cfg_train_count;
  logic [CNT_W-1:0]  cfg_charge_recovery_time;
  logic [MAG_W-1:0]  cfg_pulse_magnitude;
  logic              cfg_rising_edge_first;
  logic              cfg_bipolar_mode;
  logic [NUM_CH-1:0] cfg_mask_pos;
  logic [NUM_CH-1:0] cfg_mask_neg;
  logic              finite_start;
  logic              infinite_start;
  logic              stop;
`ifdef STIM_ABORT_EN
  logic              abort;
`endif
  logic [NUM_CH-1:0] ch_source;
  logic [NUM_CH-1:0] ch_sink;
  logic [MAG_W-1:0]  magnitude;
  logic [NUM_CH-1:0] chg_rec;
  logic              busy;
  logic              done;

  modport master (
`ifdef STIM_ABORT_EN
    output abort,
`endif
    output cfg_pulse_length, cfg_inter_pulse_delay, cfg_inter_bipulse_delay,
    output cfg_inter_train_delay, cfg_bipulses_per_train, cfg_train_count,
    output cfg_charge_recovery_time, cfg_pulse_magnitude, cfg_rising_edge_first,
    output cfg_bipolar_mode, cfg_mask_pos, cfg_mask_neg,
    output finite_start, infinite_start, stop,
    input  ch_source, ch_sink, magnitude, chg_rec, busy, done
  );

  modport slave (
`ifdef STIM_ABORT_EN
    input  abort,
`endif
    input  cfg_pulse_length, cfg_inter_pulse_delay, cfg_inter_bipulse_delay,
    input  cfg_inter_train_delay, cfg_bipulses_per_train, cfg_train_count,
    input  cfg_charge_recovery_time, cfg_pulse_magnitude, cfg_rising_edge_first,
    input  cfg_bipolar_mode, cfg_mask_pos, cfg_mask_neg,
    input  finite_start, infinite_start, stop,
    output ch_source, ch_sink, magnitude, chg_rec, busy, done
  );

endinterface

// File: rtl/stim_train_sequencer_interval_timer.sv
// Loadable down-counter shared by every timed state. The counter holds the
// cycles left in the current state; expire flags its last cycle. The zero
// flag tells the FSM that a candidate duration is 0 and the state is skipped.
module stim_train_sequencer_interval_timer #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic [CNT_W-1:0] i_peek_val,
  output logic             o_zero_c,
  output logic             o_expire_c
);
  logic [CNT_W-1:0] r_cnt;

  // Reload on state entry, otherwise count down and park at zero
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire_c = (r_cnt == CNT_W'(1));
  assign o_zero_c   = (i_peek_val == '0);

endmodule

// File: rtl/stim_train_sequencer.sv
// Biphasic stimulation pulse-train sequencer (finite/infinite runs, graceful
// charge-balanced stop, charge-recovery window). Optional macro
// STIM_ABORT_EN adds an abort input that forces recovery without phase2.
module stim_train_sequencer
  import stim_train_sequencer_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned MAG_W  = DEF_MAG_W
) (
  input logic                   clk,
  input logic                   rstn,
  stim_train_sequencer_if.slave io_bus
);
  stim_state_e       r_state, w_state_nxt, w_cand, w_fb, w_target, w_rec_target;
  logic [CNT_W-1:0]  r_pl, r_ipd, r_ibd, r_itd, r_bpt, r_tc, r_rec;
  logic [CNT_W-1:0]  w_pl, w_ipd, w_ibd, w_itd, w_rec;
  logic [CNT_W-1:0]  r_bp_idx, r_tr_idx, w_bp_nxt, w_tr_nxt, w_peek, w_load_val;
  logic [MAG_W-1:0]  r_mag_cfg, w_mag, r_mag, w_mag_nxt;
  logic [NUM_CH-1:0] r_pos, r_neg, w_pos_in, w_neg_in, w_pos, w_neg;
  logic [NUM_CH-1:0] r_src, r_snk, r_chg, w_src_nxt, w_snk_nxt, w_chg_nxt;
  logic              r_ref, w_ref, r_inf, r_stop_pend, w_stop_pend_nxt;
  logic              r_busy, r_done, w_done_nxt;
  logic              w_start_acc, w_zero_run, w_more_bp, w_more_tr, w_stop_now;
  logic              w_zero, w_expire, w_load, w_abort;

`ifdef STIM_ABORT_EN
  assign w_abort = io_bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  // Duration of a timed state under a given configuration; phases never shorter than 1
  function automatic logic [CNT_W-1:0] state_dur(input stim_state_e s,
      input logic [CNT_W-1:0] pl, input logic [CNT_W-1:0] ipd, input logic [CNT_W-1:0] ibd,
      input logic [CNT_W-1:0] itd, input logic [CNT_W-1:0] rec);
    case (s)
      ST_PHASE1, ST_PHASE2: state_dur = (pl == '0) ? CNT_W'(1) : pl;
      ST_GAP_P:             state_dur = ipd;
      ST_GAP_BP:            state_dur = ibd;
      ST_GAP_TR:            state_dur = itd;
      ST_RECOVERY:          state_dur = rec;
      default:              state_dur = '0;
    endcase
  endfunction

  // Effective masks of the incoming config (overlap and monopolar resolved)
  always_comb begin
    w_pos_in = '0;
    w_neg_in = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      {w_pos_in[i], w_neg_in[i]} = ch_eff(io_bus.cfg_mask_pos[i], io_bus.cfg_mask_neg[i],
                                          io_bus.cfg_bipolar_mode);
    end
  end

  // Config view: live inputs on the accepting edge, latched copy afterwards
  assign w_start_acc = (r_state == ST_IDLE) && (io_bus.finite_start || io_bus.infinite_start);
  assign w_zero_run  = (io_bus.cfg_bipulses_per_train == '0) || (io_bus.cfg_train_count == '0);
  assign w_pl  = w_start_acc ? io_bus.cfg_pulse_length         : r_pl;
  assign w_ipd = w_start_acc ? io_bus.cfg_inter_pulse_delay    : r_ipd;
  assign w_ibd = w_start_acc ? io_bus.cfg_inter_bipulse_delay  : r_ibd;
  assign w_itd = w_start_acc ? io_bus.cfg_inter_train_delay    : r_itd;
  assign w_rec = w_start_acc ? io_bus.cfg_charge_recovery_time : r_rec;
  assign w_mag = w_start_acc ? io_bus.cfg_pulse_magnitude      : r_mag_cfg;
  assign w_ref = w_start_acc ? io_bus.cfg_rising_edge_first    : r_ref;
  assign w_pos = w_start_acc ? w_pos_in : r_pos;
  assign w_neg = w_start_acc ? w_neg_in : r_neg;

  assign w_more_bp  = (r_bp_idx + CNT_W'(1)) < r_bpt;
  assign w_more_tr  = r_inf || ((r_tr_idx + CNT_W'(1)) < r_tc);
  assign w_stop_now = r_stop_pend || io_bus.stop;

  // Candidate successor of the current timed state and where to go if it is zero-length
  always_comb begin
    w_cand = ST_IDLE;
    w_fb   = ST_IDLE;
    case (r_state)
      ST_IDLE:   begin w_cand = ST_PHASE1; w_fb = ST_PHASE1; end
      ST_PHASE1: begin w_cand = ST_GAP_P;  w_fb = ST_PHASE2; end
      ST_GAP_P:  begin w_cand = ST_PHASE2; w_fb = ST_PHASE2; end
      ST_PHASE2: begin
        if (w_stop_now || !(w_more_bp || w_more_tr)) begin
          w_cand = ST_RECOVERY; w_fb = ST_IDLE;
        end else if (w_more_bp) begin
          w_cand = ST_GAP_BP;   w_fb = ST_PHASE1;
        end else begin
          w_cand = ST_GAP_TR;   w_fb = ST_PHASE1;
        end
      end
      ST_GAP_BP, ST_GAP_TR: begin w_cand = ST_PHASE1; w_fb = ST_PHASE1; end
      default: ;
    endcase
    w_peek = state_dur(w_cand, w_pl, w_ipd, w_ibd, w_itd, w_rec);
  end

  stim_train_sequencer_interval_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_peek_val (w_peek),
    .o_zero_c   (w_zero),
    .o_expire_c (w_expire)
  );

  // Next state, counters, stop bookkeeping and next registered outputs
  always_comb begin
    w_state_nxt  = r_state;
    w_bp_nxt     = r_bp_idx;
    w_tr_nxt     = r_tr_idx;
    w_done_nxt   = 1'b0;
    w_src_nxt    = '0;
    w_snk_nxt    = '0;
    w_chg_nxt    = '0;
    w_mag_nxt    = '0;
    w_target     = w_zero ? w_fb : w_cand;
    w_rec_target = (w_rec == '0) ? ST_IDLE : ST_RECOVERY;
    case (r_state)
      ST_IDLE: begin
        if (w_start_acc) begin
          w_bp_nxt = '0;
          w_tr_nxt = '0;
          if (io_bus.finite_start && w_zero_run) w_done_nxt = 1'b1;
          else                                   w_state_nxt = w_target;
        end
      end
      ST_PHASE1, ST_GAP_P: begin
        if (w_expire) w_state_nxt = w_target;
      end
      ST_PHASE2: begin
        if (w_expire) begin
          w_state_nxt = w_target;
          if (!w_stop_now) begin
            if (w_more_bp) begin
              w_bp_nxt = r_bp_idx + CNT_W'(1);
            end else if (w_more_tr) begin
              w_bp_nxt = '0;
              if (!r_inf) w_tr_nxt = r_tr_idx + CNT_W'(1);
            end
          end
        end
      end
      ST_GAP_BP, ST_GAP_TR: begin
        if (io_bus.stop)   w_state_nxt = w_rec_target;
        else if (w_expire) w_state_nxt = w_target;
      end
      ST_RECOVERY: begin
        if (w_expire) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_abort && (r_state != ST_IDLE) && (r_state != ST_RECOVERY)) w_state_nxt = w_rec_target;
    if ((r_state != ST_IDLE) && (w_state_nxt == ST_IDLE)) w_done_nxt = 1'b1;

    w_load     = (w_state_nxt != r_state);
    w_load_val = state_dur(w_state_nxt, w_pl, w_ipd, w_ibd, w_itd, w_rec);

    w_stop_pend_nxt = (r_state inside {ST_PHASE1, ST_GAP_P, ST_PHASE2}) &&
                      (w_state_nxt inside {ST_PHASE1, ST_GAP_P, ST_PHASE2}) && w_stop_now;

    case (w_state_nxt)
      ST_PHASE1: begin
        w_src_nxt = w_ref ? w_pos : w_neg;
        w_snk_nxt = w_ref ? w_neg : w_pos;
        w_mag_nxt = w_mag;
      end
      ST_PHASE2: begin
        w_src_nxt = w_ref ? w_neg : w_pos;
        w_snk_nxt = w_ref ? w_pos : w_neg;
        w_mag_nxt = w_mag;
      end
      ST_RECOVERY: w_chg_nxt = w_pos | w_neg;
      default: ;
    endcase
  end

  // State, counters, latched config and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_bp_idx    <= '0;
      r_tr_idx    <= '0;
      r_stop_pend <= 1'b0;
      r_pl        <= '0;
      r_ipd       <= '0;
      r_ibd       <= '0;
      r_itd       <= '0;
      r_bpt       <= '0;
      r_tc        <= '0;
      r_rec       <= '0;
      r_mag_cfg   <= '0;
      r_ref       <= 1'b0;
      r_inf       <= 1'b0;
      r_pos       <= '0;
      r_neg       <= '0;
      r_src       <= '0;
      r_snk       <= '0;
      r_chg       <= '0;
      r_mag       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bp_idx    <= w_bp_nxt;
      r_tr_idx    <= w_tr_nxt;
      r_stop_pend <= w_stop_pend_nxt;
      if (w_start_acc) begin
        r_pl      <= io_bus.cfg_pulse_length;
        r_ipd     <= io_bus.cfg_inter_pulse_delay;
        r_ibd     <= io_bus.cfg_inter_bipulse_delay;
        r_itd     <= io_bus.cfg_inter_train_delay;
        r_bpt     <= io_bus.cfg_bipulses_per_train;
        r_tc      <= io_bus.cfg_train_count;
        r_rec     <= io_bus.cfg_charge_recovery_time;
        r_mag_cfg <= io_bus.cfg_pulse_magnitude;
        r_ref     <= io_bus.cfg_rising_edge_first;
        r_inf     <= !io_bus.finite_start;
        r_pos     <= w_pos_in;
        r_neg     <= w_neg_in;
      end
      r_src  <= w_src_nxt;
      r_snk  <= w_snk_nxt;
      r_chg  <= w_chg_nxt;
      r_mag  <= w_mag_nxt;
      r_busy <= (w_state_nxt != ST_IDLE);
      r_done <= w_done_nxt;
    end
  end

  assign io_bus.ch_source = r_src;
  assign io_bus.ch_sink   = r_snk;
  assign io_bus.chg_rec   = r_chg;
  assign io_bus.magnitude = r_mag;
  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;

endmodule
